tft_timing_generator: RTL and testbench



---
 rtl/tft_timing_generator.sv | 138 +++++++++++++
 tb/tb_tft_timing_generator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tft_timing_generator.sv
// tft_timing_generator: frame sequencer running panel reset, integration and an ROI raster scan
module tft_timing_generator #(
    parameter int RESET_CYCLES   = 16,
    parameter int TICKS_PER_UNIT = 100,
    parameter int LINE_GAP       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        frame_reset,
    input  logic [15:0] integration_time,
    input  logic [11:0] row_start,
    input  logic [11:0] row_end,
    input  logic [11:0] col_start,
    input  logic [11:0] col_end,
    output logic        frame_busy,
    output logic        frame_complete
);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int PW = $clog2(TICKS_PER_UNIT + 1);
    localparam int GW = $clog2(LINE_GAP + 2);
    localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_UNIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(LINE_GAP);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        INTEGRATE = 3'd2,
        READOUT   = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t        current_state;
    logic [11:0]   current_row;
    logic [11:0]   current_col;
    logic [15:0]   integrate_counter;
    logic [RW-1:0] reset_cnt_q;
    logic [PW-1:0] tick_q;
    logic [GW-1:0] gap_q;
    logic [15:0]   time_q;
    logic [11:0]   row_first_q, row_last_q, col_first_q, col_last_q;
    logic [11:0]   row_last_d, col_last_d;
    logic [15:0]   units_d;

    // A reversed ROI collapses to its start coordinate; elapsed units after the next prescaler wrap
    always_comb begin
        row_last_d = (row_end < row_start) ? row_start : row_end;
        col_last_d = (col_end < col_start) ? col_start : col_end;
        units_d    = integrate_counter + 16'd1;
    end

    // Frame sequencer with registered busy/complete outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state     <= IDLE;
            current_row       <= '0;
            current_col       <= '0;
            integrate_counter <= '0;
            reset_cnt_q       <= '0;
            tick_q            <= '0;
            gap_q             <= '0;
            time_q            <= '0;
            row_first_q       <= '0;
            row_last_q        <= '0;
            col_first_q       <= '0;
            col_last_q        <= '0;
            frame_busy        <= 1'b0;
            frame_complete    <= 1'b0;
        end else if (frame_reset) begin
            current_state     <= IDLE;
            current_row       <= '0;
            current_col       <= '0;
            integrate_counter <= '0;
            reset_cnt_q       <= '0;
            tick_q            <= '0;
            gap_q             <= '0;
            frame_busy        <= 1'b0;
            frame_complete    <= 1'b0;
        end else begin
            frame_complete <= 1'b0;
            case (current_state)
                IDLE: if (frame_start) begin
                    time_q            <= integration_time;
                    row_first_q       <= row_start;
                    row_last_q        <= row_last_d;
                    col_first_q       <= col_start;
                    col_last_q        <= col_last_d;
                    integrate_counter <= '0;
                    reset_cnt_q       <= '0;
                    tick_q            <= '0;
                    gap_q             <= '0;
                    current_row       <= '0;
                    current_col       <= '0;
                    current_state     <= RESET;
                    frame_busy        <= 1'b1;
                end
                RESET: if (reset_cnt_q == RST_LAST) begin
                    reset_cnt_q   <= '0;
                    current_row   <= row_first_q;
                    current_col   <= col_first_q;
                    current_state <= (time_q == 16'd0) ? READOUT : INTEGRATE;
                end else begin
                    reset_cnt_q <= reset_cnt_q + 1'b1;
                end
                INTEGRATE: if (tick_q == TICK_LAST) begin
                    tick_q            <= '0;
                    integrate_counter <= units_d;
                    if (units_d == time_q) current_state <= READOUT;
                end else begin
                    tick_q <= tick_q + 1'b1;
                end
                READOUT: if (current_col != col_last_q) begin
                    current_col <= current_col + 12'd1;
                end else if (gap_q != GAP_LAST) begin
                    gap_q <= gap_q + 1'b1;
                end else begin
                    gap_q <= '0;
                    if (current_row == row_last_q) begin
                        current_state  <= DONE;
                        frame_complete <= 1'b1;
                    end else begin
                        current_row <= current_row + 12'd1;
                        current_col <= col_first_q;
                    end
                end
                DONE: begin
                    current_state <= IDLE;
                    frame_busy    <= 1'b0;
                end
                default: begin
                    current_state <= IDLE;
                    frame_busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tft_timing_generator.sv
// tb_tft_timing_generator: scoreboard bench comparing whole frames against an arithmetic frame model
module tb_tft_timing_generator;
    localparam int RC  = 16;
    localparam int TPU = 100;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        frame_reset;
    logic [15:0] integration_time;
    logic [11:0] row_start, row_end, col_start, col_end;
    logic        frame_busy;
    logic        frame_complete;

    typedef struct {
        int len;
        bit ab;
        bit integ;
        int r0, r1, c0, c1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   idle_comp = 0;

    tft_timing_generator #(
        .RESET_CYCLES(RC),
        .TICKS_PER_UNIT(TPU),
        .LINE_GAP(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .frame_reset(frame_reset),
        .integration_time(integration_time),
        .row_start(row_start),
        .row_end(row_end),
        .col_start(col_start),
        .col_end(col_end),
        .frame_busy(frame_busy),
        .frame_complete(frame_complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic exp_t model(input int t, input int rs, input int re, input int cs, input int ce);
        exp_t e;
        e.r0    = rs;
        e.r1    = (re < rs) ? rs : re;
        e.c0    = cs;
        e.c1    = (ce < cs) ? cs : ce;
        e.ab    = 1'b0;
        e.integ = (t != 0);
        e.len   = RC + t * TPU + (e.r1 - e.r0 + 1) * ((e.c1 - e.c0 + 1) + GAP) + 1;
        return e;
    endfunction

    task automatic set_in(input int t, input int rs, input int re, input int cs, input int ce);
        integration_time = 16'(t);
        row_start        = 12'(rs);
        row_end          = 12'(re);
        col_start        = 12'(cs);
        col_end          = 12'(ce);
    endtask

    task automatic scramble();
        set_in($urandom_range(0, 65535), $urandom_range(0, 4095), $urandom_range(0, 4095),
               $urandom_range(0, 4095), $urandom_range(0, 4095));
    endtask

    task automatic compare_frame(input int len, input int ncomp, input bit last_comp,
                                 input int seq, input int fall_state, input logic [23:0] pq[$]);
        exp_t e;
        logic [23:0] ep[$];
        int eseq;
        int bad;
        if (sb.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            return;
        end
        e = sb.pop_front();
        eseq = e.integ ? 12 : 1;
        if (!e.ab) eseq = eseq * 100 + 34;
        if (!e.ab)
            for (int r = e.r0; r <= e.r1; r++)
                for (int c = e.c0; c <= e.c1; c++)
                    ep.push_back({12'(r), 12'(c)});
        bad = 0;
        for (int i = 0; i < ep.size() && i < pq.size(); i++)
            if (ep[i] != pq[i]) bad++;
        chk("busy_len", len, e.len);
        chk("complete_pulses", ncomp, e.ab ? 0 : 1);
        chk("complete_last", last_comp, e.ab ? 0 : 1);
        chk("state_seq", seq, eseq);
        chk("idle_after", fall_state, 0);
        chk("scan_count", pq.size(), ep.size());
        chk("scan_order", bad, 0);
    endtask

    task automatic monitor();
        bit prev_busy = 1'b0;
        int len = 0;
        int ncomp = 0;
        bit last_comp = 1'b0;
        int seq = 0;
        int st;
        logic [23:0] pr;
        logic [23:0] pq[$];
        forever begin
            @(posedge clk);
            #1;
            st = int'(dut.current_state);
            if (frame_busy) begin
                if (!prev_busy) begin
                    len = 0;
                    ncomp = 0;
                    seq = 0;
                    pq.delete();
                end
                len++;
                ncomp += int'(frame_complete);
                last_comp = frame_complete;
                if (seq % 10 != st) seq = seq * 10 + st;
                if (st == 3) begin
                    pr = {dut.current_row, dut.current_col};
                    if (pq.size() == 0 || pq[$] != pr) pq.push_back(pr);
                end
            end else begin
                if (frame_complete) idle_comp++;
                if (prev_busy && rst_n) compare_frame(len, ncomp, last_comp, seq, st, pq);
            end
            prev_busy = frame_busy;
        end
    endtask

    task automatic run(input int t, input int rs, input int re, input int cs, input int ce,
                       input int p, input int mode);
        exp_t e;
        int k;
        e = model(t, rs, re, cs, ce);
        if (mode == 1) begin
            e.len   = RC + 21;
            e.ab    = 1'b1;
            e.integ = 1'b1;
        end
        set_in(t, rs, re, cs, ce);
        frame_start = 1'b1;
        sb.push_back(e);
        repeat (p) @(negedge clk);
        frame_start = 1'b0;
        scramble();
        if (mode == 1) begin
            repeat (RC + 20) @(negedge clk);
            frame_reset = 1'b1;
            @(negedge clk);
            frame_reset = 1'b0;
        end
        if (mode == 2) begin
            k = 0;
            while (int'(dut.current_state) != 3 && k < 2000) begin
                @(negedge clk);
                k++;
            end
            frame_start = 1'b1;
            scramble();
            @(negedge clk);
            frame_start = 1'b0;
        end
        k = 0;
        while (frame_busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("frame_ends", frame_busy, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        int hi;
        int k;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        fork
            monitor();
        join_none
        repeat (10) @(negedge clk);
        chk("rst_busy", frame_busy, 0);
        chk("rst_complete", frame_complete, 0);
        chk("rst_state", dut.current_state, 0);
        chk("rst_row", dut.current_row, 0);
        chk("rst_col", dut.current_col, 0);
        chk("rst_integ", dut.integrate_counter, 0);
        rst_n = 1'b1;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(frame_busy);
        end
        chk("idle_busy", hi, 0);
        run(1, 0, 1, 0, 1, 2, 0);
        run(0, 5, 5, 3, 6, 1, 0);
        run(3, 0, 1, 0, 1, 1, 1);
        run(2, 1, 2, 2, 4, 1, 0);
        run(1, 2, 3, 0, 3, 1, 2);
        run(0, 4, 2, 9, 1, 1, 0);
        repeat (8)
            run($urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 3),
                ($urandom_range(0, 1) == 1) ? 2 : 0);
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drained", sb.size(), 0);
        chk("idle_complete", idle_comp, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
